adjust_ctrl: RTL and testbench

Time/alarm setting controller for the digital clock. It takes snapshots of the running time or alarm registers into shadow BCD registers, and edits them field by field with left/right/up/down presses. On exit it commits the edited values back through a one-cycle load strobe. It sits between the debounced button inputs and the time-counter/alarm datapath, and drives the display mux with the edit values, the active field and the blink phase.

---
 rtl/adjust_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_adjust_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_ctrl.sv
// rtl/adjust_ctrl.sv - time/alarm edit controller with BCD shadow registers and a one-cycle commit strobe
// Optional idle auto-abort is built when ADJ_TIMEOUT_EN is defined.
module adjust_ctrl #(
    parameter int IDLE_TICKS = 20
) (
    input  logic       CP,
    input  logic       _CR,
    input  logic       adjust,
    input  logic       target_alarm,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       blink_tick,
    input  logic [7:0] cur_h,
    input  logic [7:0] cur_m,
    input  logic [7:0] cur_s,
    input  logic [7:0] alarm_h,
    input  logic [7:0] alarm_m,
    output logic       edit_active,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic [7:0] edit_h,
    output logic [7:0] edit_m,
    output logic [7:0] edit_s,
    output logic       time_load,
    output logic       alarm_load
);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT, HOLD} state_t;

    state_t     state, state_n;
    logic       adjust_q, left_q, right_q, up_q, down_q;
    logic       target_q, target_n;
    logic       edit_active_n, blink_n, time_load_n, alarm_load_n;
    logic [1:0] field_sel_n;
    logic [7:0] edit_h_n, edit_m_n, edit_s_n;

    logic adjust_rise, left_p, right_p, up_p, down_p, any_press, inc, dec;

    // Previous-sample registers reset high so a level already high at reset release is not an edge.
    assign adjust_rise = adjust & ~adjust_q;
    assign left_p      = left & ~left_q;
    assign right_p     = right & ~right_q;
    assign up_p        = up & ~up_q;
    assign down_p      = down & ~down_q;
    assign any_press   = left_p | right_p | up_p | down_p;
    assign inc         = up_p & ~down_p;
    assign dec         = down_p & ~up_p;

`ifdef ADJ_TIMEOUT_EN
    localparam int CNT_W = $clog2(IDLE_TICKS + 1);
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
`else
    logic unused_idle_ticks;
    assign unused_idle_ticks = ^IDLE_TICKS;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
        if (v == 8'h00)
            return maxv;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            state       <= IDLE;
            target_q    <= 1'b0;
            edit_active <= 1'b0;
            field_sel   <= 2'd0;
            blink       <= 1'b1;
            edit_h      <= 8'h00;
            edit_m      <= 8'h00;
            edit_s      <= 8'h00;
            time_load   <= 1'b0;
            alarm_load  <= 1'b0;
            adjust_q    <= 1'b1;
            left_q      <= 1'b1;
            right_q     <= 1'b1;
            up_q        <= 1'b1;
            down_q      <= 1'b1;
`ifdef ADJ_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            target_q    <= target_n;
            edit_active <= edit_active_n;
            field_sel   <= field_sel_n;
            blink       <= blink_n;
            edit_h      <= edit_h_n;
            edit_m      <= edit_m_n;
            edit_s      <= edit_s_n;
            time_load   <= time_load_n;
            alarm_load  <= alarm_load_n;
            adjust_q    <= adjust;
            left_q      <= left;
            right_q     <= right;
            up_q        <= up;
            down_q      <= down;
`ifdef ADJ_TIMEOUT_EN
            idle_cnt    <= idle_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        target_n      = target_q;
        edit_active_n = edit_active;
        field_sel_n   = field_sel;
        blink_n       = blink;
        edit_h_n      = edit_h;
        edit_m_n      = edit_m;
        edit_s_n      = edit_s;
        time_load_n   = 1'b0;
        alarm_load_n  = 1'b0;
`ifdef ADJ_TIMEOUT_EN
        idle_cnt_n    = idle_cnt;
`endif
        case (state)
            IDLE: begin
                edit_active_n = 1'b0;
                blink_n       = 1'b1;
                if (adjust_rise) begin
                    state_n       = EDIT;
                    edit_active_n = 1'b1;
                    target_n      = target_alarm;
`ifdef ADJ_TIMEOUT_EN
                    idle_cnt_n    = '0;
`endif
                    if (target_alarm) begin
                        edit_h_n    = alarm_h;
                        edit_m_n    = alarm_m;
                        edit_s_n    = 8'h00;
                        field_sel_n = 2'd1;
                    end else begin
                        edit_h_n    = cur_h;
                        edit_m_n    = cur_m;
                        edit_s_n    = cur_s;
                        field_sel_n = 2'd0;
                    end
                end
            end
            EDIT: begin
                if (!adjust) begin
                    // Exit takes priority: presses in this cycle never reach the committed value.
                    state_n       = COMMIT;
                    edit_active_n = 1'b0;
                    blink_n       = 1'b1;
                    time_load_n   = ~target_q;
                    alarm_load_n  = target_q;
                end else begin
                    if (inc || dec) begin
                        case (field_sel)
                            2'd0:    edit_s_n = inc ? bcd_inc(edit_s, 8'h59) : bcd_dec(edit_s, 8'h59);
                            2'd1:    edit_m_n = inc ? bcd_inc(edit_m, 8'h59) : bcd_dec(edit_m, 8'h59);
                            2'd2:    edit_h_n = inc ? bcd_inc(edit_h, 8'h23) : bcd_dec(edit_h, 8'h23);
                            default: ;
                        endcase
                    end
                    if (left_p ^ right_p) begin
                        if (target_q)
                            field_sel_n = (field_sel == 2'd2) ? 2'd1 : 2'd2;
                        else if (left_p)
                            field_sel_n = (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
                        else
                            field_sel_n = (field_sel == 2'd0) ? 2'd2 : field_sel - 2'd1;
                    end
                    if (any_press) begin
                        blink_n = 1'b1;
`ifdef ADJ_TIMEOUT_EN
                        idle_cnt_n = '0;
`endif
                    end else if (blink_tick) begin
`ifdef ADJ_TIMEOUT_EN
                        if (idle_cnt == CNT_W'(IDLE_TICKS - 1)) begin
                            state_n       = HOLD;
                            edit_active_n = 1'b0;
                            blink_n       = 1'b1;
                        end else begin
                            idle_cnt_n = idle_cnt + CNT_W'(1);
                            blink_n    = ~blink;
                        end
`else
                        blink_n = ~blink;
`endif
                    end
                end
            end
            COMMIT: state_n = IDLE;
            HOLD: begin
                if (!adjust)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adjust_ctrl.sv
// tb/tb_adjust_ctrl.sv - directed and randomized checks of adjust_ctrl against a behavioural model
module tb_adjust_ctrl;
    localparam int IDLE = 3;
`ifdef ADJ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CP, _CR, adjust, target_alarm, left, right, up, down, blink_tick;
    logic [7:0] cur_h, cur_m, cur_s, alarm_h, alarm_m;
    logic       edit_active, blink, time_load, alarm_load;
    logic [1:0] field_sel;
    logic [7:0] edit_h, edit_m, edit_s;

    int checks = 0;
    int errors = 0;

    int m_mode, m_h, m_m, m_s, m_field, m_cnt;
    bit m_active, m_blink, m_tload, m_aload, m_tgt;
    bit p_adj, p_l, p_r, p_u, p_d;

    adjust_ctrl #(.IDLE_TICKS(IDLE)) dut (
        .CP(CP), ._CR(_CR), .adjust(adjust), .target_alarm(target_alarm),
        .left(left), .right(right), .up(up), .down(down), .blink_tick(blink_tick),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .edit_active(edit_active), .field_sel(field_sel), .blink(blink),
        .edit_h(edit_h), .edit_m(edit_m), .edit_s(edit_s),
        .time_load(time_load), .alarm_load(alarm_load)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_field = 0; m_cnt = 0;
        m_active = 0; m_blink = 1; m_tload = 0; m_aload = 0; m_tgt = 0;
        p_adj = 1; p_l = 1; p_r = 1; p_u = 1; p_d = 1;
    endtask

    task automatic model_step();
        bit pu, pd, pl, pr;
        pu = up && !p_u; pd = down && !p_d; pl = left && !p_l; pr = right && !p_r;
        m_tload = 0; m_aload = 0;
        case (m_mode)
            0: begin
                m_active = 0; m_blink = 1;
                if (adjust && !p_adj) begin
                    m_mode = 1; m_active = 1; m_tgt = target_alarm; m_cnt = 0;
                    if (target_alarm) begin
                        m_h = from_bcd(alarm_h); m_m = from_bcd(alarm_m); m_s = 0; m_field = 1;
                    end else begin
                        m_h = from_bcd(cur_h); m_m = from_bcd(cur_m); m_s = from_bcd(cur_s); m_field = 0;
                    end
                end
            end
            1: begin
                if (!adjust) begin
                    m_mode = 2; m_active = 0; m_blink = 1; m_tload = !m_tgt; m_aload = m_tgt;
                end else begin
                    if (pu != pd) begin
                        case (m_field)
                            0: m_s = pu ? (m_s + 1) % 60 : (m_s + 59) % 60;
                            1: m_m = pu ? (m_m + 1) % 60 : (m_m + 59) % 60;
                            default: m_h = pu ? (m_h + 1) % 24 : (m_h + 23) % 24;
                        endcase
                    end
                    if (pl != pr) m_field = m_tgt ? 3 - m_field : (pl ? (m_field + 1) % 3 : (m_field + 2) % 3);
                    if (pu || pd || pl || pr) begin
                        m_blink = 1; m_cnt = 0;
                    end else if (blink_tick) begin
                        m_cnt++;
                        if (TO_EN && m_cnt >= IDLE) begin
                            m_mode = 3; m_active = 0; m_blink = 1;
                        end else m_blink = !m_blink;
                    end
                end
            end
            2: m_mode = 0;
            default: if (!adjust) m_mode = 0;
        endcase
        p_adj = adjust; p_l = left; p_r = right; p_u = up; p_d = down;
    endtask

    task automatic tick();
        model_step();
        @(posedge CP); #1;
    endtask

    task automatic press(input int b);
        case (b)
            0: up = 1; 1: down = 1; 2: left = 1; default: right = 1;
        endcase
        tick();
        up = 0; down = 0; left = 0; right = 0;
        tick();
    endtask

    task automatic do_reset();
        _CR = 0;
        model_reset();
        @(posedge CP); #2;
        _CR = 1;
    endtask

    task automatic enter(input bit tgt);
        adjust = 0; target_alarm = tgt; tick();
        adjust = 1; tick();
        target_alarm = 0;
    endtask

    task automatic test_reset();
        _CR = 0; adjust = 1; model_reset();
        #12;
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b exp 0", edit_active); end
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL rst_field got %0d exp 0", field_sel); end
        checks++; if ({edit_h, edit_m, edit_s} !== 24'h0) begin errors++; $display("FAIL rst_edit got %h exp 000000", {edit_h, edit_m, edit_s}); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL rst_blink got %0b exp 1", blink); end
        checks++; if ({time_load, alarm_load} !== 2'b00) begin errors++; $display("FAIL rst_load got %b exp 00", {time_load, alarm_load}); end
        @(posedge CP); #2; _CR = 1;
        tick(); tick(); tick();
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL startup_adjust_high got %0b exp 0", edit_active); end
    endtask

    task automatic test_enter_commit();
        cur_h = 8'h12; cur_m = 8'h34; cur_s = 8'h56;
        enter(0);
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL enter_active got %0b exp 1", edit_active); end
        checks++; if ({edit_h, edit_m, edit_s} !== 24'h123456) begin errors++; $display("FAIL enter_snapshot got %h exp 123456", {edit_h, edit_m, edit_s}); end
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL enter_field got %0d exp 0", field_sel); end
        repeat (3) press(0);
        checks++; if (edit_s !== 8'h59) begin errors++; $display("FAIL up3_sec got %h exp 59", edit_s); end
        press(0);
        checks++; if (edit_s !== 8'h00) begin errors++; $display("FAIL sec_wrap got %h exp 00", edit_s); end
        adjust = 0; tick();
        checks++; if ({time_load, alarm_load, edit_active} !== 3'b100) begin errors++; $display("FAIL commit_strobe got %b exp 100", {time_load, alarm_load, edit_active}); end
        checks++; if ({edit_h, edit_m, edit_s} !== 24'h123400) begin errors++; $display("FAIL commit_value got %h exp 123400", {edit_h, edit_m, edit_s}); end
        tick();
        checks++; if (time_load !== 1'b0) begin errors++; $display("FAIL commit_one_cycle got %0b exp 0", time_load); end
    endtask

    task automatic test_hour_cursor();
        cur_h = 8'h23; cur_m = 8'h00; cur_s = 8'h00;
        enter(0);
        press(2); press(2);
        checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL left2_field got %0d exp 2", field_sel); end
        press(0);
        checks++; if (edit_h !== 8'h00) begin errors++; $display("FAIL hour_up_wrap got %h exp 00", edit_h); end
        press(1);
        checks++; if (edit_h !== 8'h23) begin errors++; $display("FAIL hour_down_wrap got %h exp 23", edit_h); end
        press(2);
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL left_wrap got %0d exp 0", field_sel); end
        press(3);
        checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL right_wrap got %0d exp 2", field_sel); end
        adjust = 0; tick(); tick();
    endtask

    task automatic test_alarm();
        alarm_h = 8'h06; alarm_m = 8'h00; cur_s = 8'h45;
        enter(1);
        checks++; if ({field_sel, edit_h, edit_m, edit_s} !== {2'd1, 24'h060000}) begin errors++; $display("FAIL alarm_enter got %0d/%h exp 1/060000", field_sel, {edit_h, edit_m, edit_s}); end
        press(3);
        checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL alarm_right1 got %0d exp 2", field_sel); end
        press(3);
        checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL alarm_right2 got %0d exp 1", field_sel); end
        press(1);
        checks++; if (edit_m !== 8'h59) begin errors++; $display("FAIL alarm_min_down got %h exp 59", edit_m); end
        adjust = 0; tick();
        checks++; if ({alarm_load, time_load} !== 2'b10) begin errors++; $display("FAIL alarm_commit got %b exp 10", {alarm_load, time_load}); end
        tick();
    endtask

    task automatic test_simultaneous();
        cur_h = 8'h10; cur_m = 8'h20; cur_s = 8'h30;
        enter(0);
        up = 1; down = 1; tick(); up = 0; down = 0; tick();
        checks++; if (edit_s !== 8'h30) begin errors++; $display("FAIL updown_same got %h exp 30", edit_s); end
        left = 1; right = 1; tick(); left = 0; right = 0; tick();
        checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL leftright_same got %0d exp 0", field_sel); end
        up = 1; left = 1; tick(); up = 0; left = 0; tick();
        checks++; if ({field_sel, edit_s} !== {2'd1, 8'h31}) begin errors++; $display("FAIL up_with_left got %0d/%h exp 1/31", field_sel, edit_s); end
        up = 1; adjust = 0; tick(); up = 0;
        checks++; if ({time_load, edit_m, edit_s} !== {1'b1, 16'h2031}) begin errors++; $display("FAIL up_at_exit got %b/%h exp 1/2031", time_load, {edit_m, edit_s}); end
        tick();
    endtask

    task automatic test_blink();
        cur_h = 8'h01; cur_m = 8'h02; cur_s = 8'h03;
        enter(0);
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_entry got %0b exp 1", blink); end
        blink_tick = 1; tick(); blink_tick = 0;
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle got %0b exp 0", blink); end
        blink_tick = 1; up = 1; tick(); blink_tick = 0; up = 0;
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_press_wins got %0b exp 1", blink); end
        adjust = 0; tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_outside got %0b exp 1", blink); end
        tick();
    endtask

`ifdef ADJ_TIMEOUT_EN
    task automatic test_timeout();
        bit seen_load;
        seen_load = 0;
        cur_h = 8'h07; cur_m = 8'h08; cur_s = 8'h09;
        enter(0);
        repeat (IDLE) begin
            blink_tick = 1; tick(); blink_tick = 0;
            seen_load |= time_load | alarm_load;
            tick();
            seen_load |= time_load | alarm_load;
        end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL timeout_exit got %0b exp 0", edit_active); end
        checks++; if (seen_load !== 1'b0) begin errors++; $display("FAIL timeout_no_load got %0b exp 0", seen_load); end
        checks++; if ({edit_h, edit_m, edit_s} !== 24'h070809) begin errors++; $display("FAIL timeout_keep got %h exp 070809", {edit_h, edit_m, edit_s}); end
        tick(); tick();
        checks++; if (edit_active !== 1'b0) begin errors++; $display("FAIL hold_no_reentry got %0b exp 1'b0", edit_active); end
        adjust = 0; tick(); adjust = 1; tick();
        checks++; if (edit_active !== 1'b1) begin errors++; $display("FAIL reentry got %0b exp 1", edit_active); end
        adjust = 0; tick(); tick();
    endtask
`endif

    task automatic test_reset_midedit();
        cur_h = 8'h11; cur_m = 8'h22; cur_s = 8'h33;
        enter(0);
        press(0);
        #3; _CR = 0; model_reset();
        #1;
        checks++; if ({edit_active, field_sel, blink, edit_h, edit_m, edit_s, time_load, alarm_load} !== {1'b0, 2'd0, 1'b1, 24'h0, 2'b00})
            begin errors++; $display("FAIL midedit_reset got %b exp all reset values", {edit_active, field_sel, blink, edit_h, edit_m, edit_s, time_load, alarm_load}); end
        adjust = 0;
        @(posedge CP); #2; _CR = 1;
        tick();
        checks++; if ({time_load, alarm_load} !== 2'b00) begin errors++; $display("FAIL midedit_no_load got %b exp 00", {time_load, alarm_load}); end
    endtask

    task automatic test_random();
        adjust = 0; up = 0; down = 0; left = 0; right = 0; blink_tick = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cur_h = to_bcd($urandom_range(0, 23)); cur_m = to_bcd($urandom_range(0, 59));
            cur_s = to_bcd($urandom_range(0, 59)); alarm_h = to_bcd($urandom_range(0, 23));
            alarm_m = to_bcd($urandom_range(0, 59)); target_alarm = $urandom_range(0, 1) == 0;
            if (adjust) adjust = $urandom_range(0, 39) != 0;
            else        adjust = $urandom_range(0, 7) == 0;
            up = $urandom_range(0, 5) == 0; down = $urandom_range(0, 5) == 0;
            left = $urandom_range(0, 5) == 0; right = $urandom_range(0, 5) == 0;
            blink_tick = $urandom_range(0, 4) == 0;
            tick();
            checks++; if (edit_active !== m_active) begin errors++; $display("FAIL rnd_active cyc %0d got %0b exp %0b", i, edit_active, m_active); end
            checks++; if (field_sel !== 2'(m_field)) begin errors++; $display("FAIL rnd_field cyc %0d got %0d exp %0d", i, field_sel, m_field); end
            checks++; if (blink !== m_blink) begin errors++; $display("FAIL rnd_blink cyc %0d got %0b exp %0b", i, blink, m_blink); end
            checks++; if (edit_h !== to_bcd(m_h)) begin errors++; $display("FAIL rnd_h cyc %0d got %h exp %h", i, edit_h, to_bcd(m_h)); end
            checks++; if (edit_m !== to_bcd(m_m)) begin errors++; $display("FAIL rnd_m cyc %0d got %h exp %h", i, edit_m, to_bcd(m_m)); end
            checks++; if (edit_s !== to_bcd(m_s)) begin errors++; $display("FAIL rnd_s cyc %0d got %h exp %h", i, edit_s, to_bcd(m_s)); end
            checks++; if (time_load !== m_tload) begin errors++; $display("FAIL rnd_tload cyc %0d got %0b exp %0b", i, time_load, m_tload); end
            checks++; if (alarm_load !== m_aload) begin errors++; $display("FAIL rnd_aload cyc %0d got %0b exp %0b", i, alarm_load, m_aload); end
        end
    endtask

    initial begin
        _CR = 0; adjust = 0; target_alarm = 0; left = 0; right = 0; up = 0; down = 0; blink_tick = 0;
        cur_h = 0; cur_m = 0; cur_s = 0; alarm_h = 0; alarm_m = 0;
        test_reset();
        test_enter_commit();
        test_hour_cursor();
        test_alarm();
        test_simultaneous();
        test_blink();
`ifdef ADJ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midedit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
